// File: rtl/upsample_pkg.sv
// Shared definitions for the upsample reader: FSM encoding, default frame
// geometry (common with the down sampler) and a width helper.
package upsample_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REPEAT = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DATA_W_DEF    = 8;
  localparam int IN_WIDTH_DEF  = 320;
  localparam int IN_HEIGHT_DEF = 240;

  // Counter width for a limit, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// One-line pixel store for vertical doubling: one write port, one read port,
// synchronous read with 1-cycle latency.
module upsample_line_buf #(
  parameter int IN_WIDTH = 320,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [IN_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/upsample_reader.sv
// 2x nearest-neighbour upsampler fed from the Gaussian stage FIFO.
// Optional `UPSAMPLE_STALL_CNT_EN adds a saturating per-frame stall counter.
module upsample_reader
  import upsample_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int IN_HEIGHT = IN_HEIGHT_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic              proto_err,
`ifdef UPSAMPLE_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        state_dbg
);

  localparam int COL_W  = clog2_min1(IN_WIDTH);
  localparam int ROW_W  = clog2_min1(IN_HEIGHT);
  localparam int OROW_W = clog2_min1(2 * IN_HEIGHT);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
  localparam logic [OROW_W-1:0] OROW_LAST = OROW_W'(2 * IN_HEIGHT - 1);

  state_t            state;
  logic [COL_W-1:0]  col;       // next source pixel to capture in this line
  logic [COL_W-1:0]  hold_col;  // source column of the pixel in hold
  logic              line_full; // all pixels of the line captured
  logic [ROW_W-1:0]  row;
  logic [OROW_W-1:0] out_row;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  logic              phase;
  logic              pend;

  logic              can_issue, lb_re, fifo_cap, lb_cap, cap, xfer, line_end;
  logic [DATA_W-1:0] cap_data, lb_rdata;

  // Stream handshake: a pixel moves when out_valid && out_ready on a clock
  // edge; while out_valid is high and out_ready low, data and flags hold.
  assign xfer      = hold_v && out_ready;
  assign can_issue = !pend && !line_full && (!hold_v || (phase && out_ready));
  assign fifo_rd_en = !rst && (state == FILL) && !fifo_empty && can_issue;
  assign lb_re      = (state == REPEAT) && can_issue;
  assign fifo_cap   = (state == FILL) && pend && fifo_valid;
  assign lb_cap     = (state == REPEAT) && pend;
  assign cap        = fifo_cap || lb_cap;
  assign cap_data   = fifo_cap ? fifo_dout : lb_rdata;
  assign line_end   = xfer && phase && (hold_col == COL_LAST);

  assign out_valid = hold_v && !rst;
  assign out_data  = hold;
  assign out_sof   = hold_v && (out_row == '0) && (hold_col == '0) && !phase;
  assign out_eol   = hold_v && phase && (hold_col == COL_LAST);
  assign out_eof   = out_eol && (out_row == OROW_LAST);
  assign state_dbg = state;

  upsample_line_buf #(
    .IN_WIDTH(IN_WIDTH),
    .DATA_W  (DATA_W),
    .ADDR_W  (COL_W)
  ) u_line_buf (
    .clk  (clk),
    .we   (fifo_cap),
    .waddr(col),
    .wdata(fifo_dout),
    .re   (lb_re),
    .raddr(col),
    .rdata(lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      col        <= '0;
      hold_col   <= '0;
      line_full  <= 1'b0;
      row        <= '0;
      out_row    <= '0;
      hold       <= '0;
      hold_v     <= 1'b0;
      phase      <= 1'b0;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Only a FIFO read issued in FILL may legitimately return data.
      if (fifo_valid && !((state == FILL) && pend)) proto_err <= 1'b1;
      if (fifo_rd_en || lb_re) pend <= 1'b1;
      if (xfer) begin
        if (phase) begin
          hold_v <= 1'b0;
          phase  <= 1'b0;
        end else begin
          phase <= 1'b1;
        end
      end
      if (cap) begin
        pend     <= 1'b0;
        hold     <= cap_data;
        hold_v   <= 1'b1;
        phase    <= 1'b0;
        hold_col <= col;
        if (col == COL_LAST) line_full <= 1'b1;
        else                 col       <= col + COL_W'(1);
      end
      case (state)
        FILL: begin
          if (line_end) begin
            state     <= REPEAT;
            col       <= '0;
            line_full <= 1'b0;
            out_row   <= out_row + OROW_W'(1);
          end
        end
        REPEAT: begin
          if (line_end) begin
            if (row == ROW_LAST) begin
              state      <= DONE;
              out_row    <= '0;
              frame_done <= 1'b1;
            end else begin
              state     <= FILL;
              row       <= row + ROW_W'(1);
              out_row   <= out_row + OROW_W'(1);
              col       <= '0;
              line_full <= 1'b0;
            end
          end
        end
        DONE: begin
          state     <= FILL;
          row       <= '0;
          col       <= '0;
          line_full <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef UPSAMPLE_STALL_CNT_EN
  // Value stays visible during the frame_done cycle, then restarts.
  always_ff @(posedge clk) begin
    if (rst || frame_done) stall_cnt <= '0;
    else if (hold_v && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_upsample_reader.sv
// Directed bench for upsample_reader on a 4x2 frame with a FIFO model,
// expected-pixel queue and stream-stability monitor.
module tb_upsample_reader;
  import upsample_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;
  localparam int EW = DW + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fifo_empty = 1'b1;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_dout  = '0;
  logic          out_ready  = 1'b0;
  logic          fifo_rd_en, out_valid, out_sof, out_eol, out_eof;
  logic          frame_done, proto_err;
  logic [DW-1:0] out_data;
  logic [1:0]    state_dbg;
`ifdef UPSAMPLE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  int            bench_stall = 0;
  logic          prev_done = 1'b0;
`endif

  upsample_reader #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_valid(fifo_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .frame_done(frame_done),
    .proto_err (proto_err),
`ifdef UPSAMPLE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- bench state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  logic          rd_pend_tb = 1'b0;
  logic [DW-1:0] rd_data_tb = '0;
  logic          inject = 1'b0;
  int            ready_mode = 0;  // 0: always ready, 1: toggle, 2: stall budget
  int            stall_left = 0;
  logic          prev_stalled = 1'b0;
  logic          prev_eof_xfer = 1'b0;
  logic [EW-1:0] prev_out = '0;
  int            done_cnt = 0;
  int            last_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver + monitor, one clock per call ----------------
  task automatic cycle();
    logic [EW-1:0] cur, exp_v;
    @(negedge clk);
    fifo_valid = rd_pend_tb || inject;
    fifo_dout  = rd_pend_tb ? rd_data_tb : 8'hAA;
    rd_pend_tb = 1'b0;
    inject     = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: begin
        out_ready = !(out_valid && stall_left > 0);
        if (!out_ready) stall_left--;
      end
    endcase
    #1;
    cur = {out_eof, out_eol, out_sof, out_data};
    if (fifo_rd_en) begin
      check("rd_en_while_empty", fifo_empty, 1'b0);
      if (fifo_q.size() > 0) begin
        rd_data_tb = fifo_q.pop_front();
        rd_pend_tb = 1'b1;
      end
    end
    check("frame_done", frame_done, prev_eof_xfer);
    if (prev_stalled) begin
      check("stall_hold_valid", out_valid, 1'b1);
      check("stall_hold_data", cur, prev_out);
    end
    if (out_valid && out_ready) begin
      // all-ones sentinel (sof and eof together) is never a legal pixel
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'b1}};
      check("pixel", cur, exp_v);
    end
    prev_eof_xfer = out_valid && out_ready && out_eof;
    prev_stalled  = out_valid && !out_ready;
    prev_out      = cur;
`ifdef UPSAMPLE_STALL_CNT_EN
    if (frame_done) check("stall_cnt_at_done", stall_cnt, bench_stall);
    if (prev_done)  check("stall_cnt_cleared", stall_cnt, 0);
    if (frame_done || rst) bench_stall = 0;
    if (out_valid && !out_ready) bench_stall++;
    prev_done = frame_done;
`endif
    if (frame_done) done_cnt++;
  endtask

  task automatic load_frame(input int base);
    int orow, ocol;
    logic sof, eol, eof;
    for (int r = 0; r < H; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < W; c++)
          for (int ph = 0; ph < 2; ph++) begin
            orow = 2 * r + rep;
            ocol = 2 * c + ph;
            sof  = (orow == 0) && (ocol == 0);
            eol  = (ocol == 2 * W - 1);
            eof  = eol && (orow == 2 * H - 1);
            exp_q.push_back({eof, eol, sof, DW'(base + r * W + c)});
          end
  endtask

  task automatic push_pixels(input int first, input int last);
    for (int p = first; p <= last; p++) fifo_q.push_back(DW'(p));
  endtask

  task automatic run_frame(input int budget, input string tag);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    last_cycles = n;
    cycle();
    check({tag, "_state_fill"}, state_dbg, FILL);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_sof, out_eol, out_eof}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_state", state_dbg, FILL);
    rst = 1'b0;

    // full frame, always ready
    ready_mode = 0;
    load_frame(1);
    push_pixels(1, 8);
    run_frame(100, "basic");
    check("basic_latency_le60", last_cycles <= 60, 1);

    // same frame, ready toggling every cycle
    ready_mode = 1;
    load_frame(1);
    push_pixels(1, 8);
    run_frame(300, "toggle");

    // FIFO runs dry after pixel 2
    ready_mode = 0;
    load_frame(1);
    push_pixels(1, 2);
    n = 0;
    while (exp_q.size() > 28 && n < 50) begin
      cycle();
      n++;
    end
    check("gap_reach", exp_q.size(), 28);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("gap_out_valid", out_valid, 0);
      check("gap_rd_en", fifo_rd_en, 0);
    end
    push_pixels(3, 8);
    run_frame(100, "gap");

    // unsolicited fifo_valid
    inject = 1'b1;
    cycle();
    cycle();
    check("proto_set", proto_err, 1);
    check("proto_no_capture", out_valid, 0);
    repeat (5) cycle();
    check("proto_sticky", proto_err, 1);
    check("proto_no_capture_late", out_valid, 0);

    // reset during the second REPEAT line, then a fresh frame
    load_frame(1);
    push_pixels(1, 8);
    n = 0;
    while (exp_q.size() > 5 && n < 100) begin
      cycle();
      n++;
    end
    check("midrst_state", state_dbg, REPEAT);
    rst = 1'b1;
    cycle();
    check("midrst_c1_valid", out_valid, 0);
    check("midrst_c1_rd_en", fifo_rd_en, 0);
    cycle();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_flags", {out_sof, out_eol, out_eof, frame_done}, 0);
    check("midrst_proto", proto_err, 0);
    check("midrst_state_fill", state_dbg, FILL);
    cycle();
    exp_q.delete();
    fifo_q.delete();
    rst = 1'b0;
    load_frame(9);
    push_pixels(9, 16);
    run_frame(100, "after_rst");
    check("after_rst_proto", proto_err, 0);

    // exactly five stalled cycles in one frame
    ready_mode = 2;
    stall_left = 5;
    load_frame(1);
    push_pixels(1, 8);
    run_frame(150, "stall5");
    check("stall5_budget_used", stall_left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
